aurora_pattern_gen_check: RTL and testbench



---
 rtl/aurora_pattern_pkg.sv | 27 ++
 rtl/aurora_pattern_lanes.sv | 21 ++
 rtl/aurora_pattern_gen_check.sv | 180 ++++++++++++++++++
 tb/tb_aurora_pattern_gen_check.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aurora_pattern_pkg.sv
// Shared definitions for the Aurora link-test pattern generator/checker:
// LFSR stepping, per-lane salting and the checker state encoding.
package aurora_pattern_pkg;

    localparam int          LFSR_W    = 16;
    // Feedback taps for x^16+x^14+x^13+x^11+1 (state bits 15, 13, 12, 10)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    // Per-lane salt so that parallel lanes never carry identical words
    localparam logic [15:0] LANE_SALT = 16'h9E37;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCK   = 2'd2
    } chk_state_e;

    // Fibonacci step: shift left, feed the XOR of the tapped bits into bit 0
    function automatic logic [LFSR_W-1:0] lfsr16_next(input logic [LFSR_W-1:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

    // Lane i carries the state XORed with i*salt (mod 2^16); lane 0 is raw
    function automatic logic [LFSR_W-1:0] lane_word(input logic [LFSR_W-1:0] s, input int i);
        return s ^ (LANE_SALT * 16'(i));
    endfunction

endpackage

// File: rtl/aurora_pattern_lanes.sv
// Combinational fan-out of one 16-bit LFSR state into the full stream word.
// Lane 0 sits in the most significant 16 bits ([0:15]) of the stream.
module aurora_pattern_lanes
    import aurora_pattern_pkg::*;
#(
    parameter int N_LANE     = 1,
    parameter int DATA_WIDTH = 16*N_LANE
) (
    input  logic [LFSR_W-1:0]     lfsr_state_s,
    output logic [0:DATA_WIDTH-1] stream_s
);

    // Build every lane word from the common state
    always_comb begin
        stream_s = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < N_LANE; i++) begin
            stream_s[16*i +: 16] = lane_word(lfsr_state_s, i);
        end
    end

endmodule

// File: rtl/aurora_pattern_gen_check.sv
// Aurora streaming link-test block: transmits a per-lane LFSR pattern and
// checks the received stream against a locally regenerated copy, reporting
// lock, per-word error pulses and a saturating error count.
module aurora_pattern_gen_check
    import aurora_pattern_pkg::*;
#(
    parameter int          N_LANE     = 1,
    parameter int          DATA_WIDTH = 16*N_LANE,
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter int          LOCK_WORDS = 4,
    parameter int          LOSS_WORDS = 8,
    parameter int          ERR_W      = 16
) (
    input  logic                  USER_CLK,
    input  logic                  RESET,
    input  logic                  CHANNEL_UP,
    output logic [0:DATA_WIDTH-1] TX_D,
    output logic                  TX_SRC_RDY_N,
    input  logic                  TX_DST_RDY_N,
    input  logic [0:DATA_WIDTH-1] RX_D,
    input  logic                  RX_SRC_RDY_N,
    output logic                  LOCKED,
    output logic                  ERR_PULSE,
    output logic [ERR_W-1:0]      ERR_COUNT
);

    localparam int MC_W = $clog2(LOCK_WORDS + 1);
    localparam int LC_W = $clog2(LOSS_WORDS + 1);

    // ---------------- generator ----------------
    logic [LFSR_W-1:0]     gs_r;
    logic [0:DATA_WIDTH-1] tx_d_r;
    logic                  tx_src_rdy_n_r;
    logic [LFSR_W-1:0]     gen_load_s;
    logic [0:DATA_WIDTH-1] gen_stream_s;
    logic                  xfer_s;

    // On reset the lane mapper sees SEED so TX_D comes up as SEED's words
    assign gen_load_s = RESET ? SEED : lfsr16_next(gs_r);
    assign xfer_s     = ~tx_src_rdy_n_r & ~TX_DST_RDY_N;

    aurora_pattern_lanes #(.N_LANE(N_LANE), .DATA_WIDTH(DATA_WIDTH)) u_gen_lanes (
        .lfsr_state_s (gen_load_s),
        .stream_s     (gen_stream_s)
    );

    // Generator state and TX word: advance only on an accepted transfer
    always_ff @(posedge USER_CLK) begin
        if (RESET) begin
            gs_r           <= SEED;
            tx_d_r         <= gen_stream_s;
            tx_src_rdy_n_r <= 1'b1;
        end else begin
            tx_src_rdy_n_r <= ~CHANNEL_UP;
            if (xfer_s) begin
                gs_r   <= gen_load_s;
                tx_d_r <= gen_stream_s;
            end
        end
    end

    // ---------------- checker ----------------
    chk_state_e            state_r, state_nxt_s;
    logic [LFSR_W-1:0]     es_r, es_nxt_s;
    logic [MC_W-1:0]       mc_r, mc_nxt_s;
    logic [LC_W-1:0]       lc_r, lc_nxt_s;
    logic [ERR_W-1:0]      err_count_r, cnt_nxt_s;
    logic                  err_pulse_r, pulse_nxt_s;
    logic                  locked_r;
    logic [0:DATA_WIDTH-1] exp_stream_s;
    logic [LFSR_W-1:0]     rx_lane0_s;
    logic                  rx_valid_s;
    logic                  rx_match_s;

    aurora_pattern_lanes #(.N_LANE(N_LANE), .DATA_WIDTH(DATA_WIDTH)) u_chk_lanes (
        .lfsr_state_s (es_r),
        .stream_s     (exp_stream_s)
    );

    assign rx_lane0_s = RX_D[0:15];
    assign rx_valid_s = ~RX_SRC_RDY_N & CHANNEL_UP;
    assign rx_match_s = (RX_D == exp_stream_s);

    // Checker next state, expected-state stepping and error accounting
    always_comb begin
        state_nxt_s = state_r;
        es_nxt_s    = es_r;
        mc_nxt_s    = mc_r;
        lc_nxt_s    = lc_r;
        pulse_nxt_s = 1'b0;
        cnt_nxt_s   = err_count_r;
        if (!CHANNEL_UP) begin
            // A channel drop wins over any word seen in the same cycle
            state_nxt_s = HUNT;
            mc_nxt_s    = {MC_W{1'b0}};
            lc_nxt_s    = {LC_W{1'b0}};
        end else if (rx_valid_s) begin
            case (state_r)
                HUNT: begin
                    // An all-zero lane 0 cannot seed the LFSR, so skip it
                    if (rx_lane0_s != 16'h0000) begin
                        es_nxt_s    = lfsr16_next(rx_lane0_s);
                        mc_nxt_s    = {MC_W{1'b0}};
                        state_nxt_s = VERIFY;
                    end else begin
                        state_nxt_s = HUNT;
                    end
                end
                VERIFY: begin
                    if (rx_match_s) begin
                        es_nxt_s = lfsr16_next(es_r);
                        mc_nxt_s = mc_r + 1'b1;
                        if (mc_r == MC_W'(LOCK_WORDS - 1)) begin
                            state_nxt_s = LOCK;
                            lc_nxt_s    = {LC_W{1'b0}};
                        end else begin
                            state_nxt_s = VERIFY;
                        end
                    end else begin
                        state_nxt_s = HUNT;
                    end
                end
                LOCK: begin
                    // Once locked the expected sequence free-runs on valid words
                    es_nxt_s = lfsr16_next(es_r);
                    if (rx_match_s) begin
                        lc_nxt_s    = {LC_W{1'b0}};
                        state_nxt_s = LOCK;
                    end else begin
                        pulse_nxt_s = 1'b1;
                        lc_nxt_s    = lc_r + 1'b1;
                        if (err_count_r != {ERR_W{1'b1}}) begin
                            cnt_nxt_s = err_count_r + 1'b1;
                        end else begin
                            cnt_nxt_s = err_count_r;
                        end
                        if (lc_r == LC_W'(LOSS_WORDS - 1)) begin
                            state_nxt_s = HUNT;
                        end else begin
                            state_nxt_s = LOCK;
                        end
                    end
                end
                default: begin
                    state_nxt_s = HUNT;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Checker state register and registered status outputs
    always_ff @(posedge USER_CLK) begin
        if (RESET) begin
            state_r     <= HUNT;
            es_r        <= 16'h0000;
            mc_r        <= {MC_W{1'b0}};
            lc_r        <= {LC_W{1'b0}};
            err_count_r <= {ERR_W{1'b0}};
            err_pulse_r <= 1'b0;
            locked_r    <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            es_r        <= es_nxt_s;
            mc_r        <= mc_nxt_s;
            lc_r        <= lc_nxt_s;
            err_count_r <= cnt_nxt_s;
            err_pulse_r <= pulse_nxt_s;
            locked_r    <= (state_nxt_s == LOCK);
        end
    end

    assign TX_D         = tx_d_r;
    assign TX_SRC_RDY_N = tx_src_rdy_n_r;
    assign LOCKED       = locked_r;
    assign ERR_PULSE    = err_pulse_r;
    assign ERR_COUNT    = err_count_r;

endmodule

// File: tb/tb_aurora_pattern_gen_check.sv
// Self-checking bench for aurora_pattern_gen_check: randomized loopback
// traffic with backpressure, injected errors and channel drops, compared
// every cycle against a behavioural model plus directed scenario checks.
module tb_aurora_pattern_gen_check;

    localparam int          N_LANE     = 3;
    localparam int          DW         = 16*N_LANE;
    localparam logic [15:0] SEED       = 16'hACE1;
    localparam int          LOCK_WORDS = 4;
    localparam int          LOSS_WORDS = 8;
    localparam int          ERR_W      = 4;
    localparam int          M_HUNT     = 0;
    localparam int          M_VERIFY   = 1;
    localparam int          M_LOCK     = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              channel_up = 1'b0;
    logic [0:DW-1]     tx_d;
    logic              tx_src_rdy_n;
    logic              tx_dst_rdy_n = 1'b1;
    logic [0:DW-1]     rx_d = {DW{1'b0}};
    logic              rx_src_rdy_n = 1'b1;
    logic              locked;
    logic              err_pulse;
    logic [ERR_W-1:0]  err_count;

    always #5 clk = ~clk;

    aurora_pattern_gen_check #(
        .N_LANE(N_LANE), .DATA_WIDTH(DW), .SEED(SEED),
        .LOCK_WORDS(LOCK_WORDS), .LOSS_WORDS(LOSS_WORDS), .ERR_W(ERR_W)
    ) dut (
        .USER_CLK     (clk),
        .RESET        (reset),
        .CHANNEL_UP   (channel_up),
        .TX_D         (tx_d),
        .TX_SRC_RDY_N (tx_src_rdy_n),
        .TX_DST_RDY_N (tx_dst_rdy_n),
        .RX_D         (rx_d),
        .RX_SRC_RDY_N (rx_src_rdy_n),
        .LOCKED       (locked),
        .ERR_PULSE    (err_pulse),
        .ERR_COUNT    (err_count)
    );

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    logic [15:0] gs_m      = SEED;
    logic [15:0] es_m      = 16'h0000;
    logic        txrdy_n_m = 1'b1;
    logic        pulse_m   = 1'b0;
    int          mode_m    = M_HUNT;
    int          run_m     = 0;
    int          miss_m    = 0;
    int          cnt_m     = 0;

    logic [0:DW-1] nf = {DW{1'b0}};

    function automatic logic [15:0] nxt(input logic [15:0] s);
        int v;
        v = int'(s);
        return 16'(((v * 2) % 65536) | (((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1));
    endfunction

    function automatic logic [0:DW-1] stream(input logic [15:0] s);
        logic [0:DW-1] r;
        int w;
        r = {DW{1'b0}};
        for (int i = 0; i < N_LANE; i++) begin
            w = int'(s) ^ ((40503 * i) % 65536);
            r[16*i +: 16] = 16'(w);
        end
        return r;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, compare every output
    task automatic step(input logic rst, input logic cu, input logic dst_n,
                        input logic [0:DW-1] flip, input logic zero_word);
        logic [0:DW-1] rx;
        logic          rx_n;
        logic          ok;
        @(negedge clk);
        rx   = zero_word ? stream(16'h0000) : (stream(gs_m) ^ flip);
        rx_n = txrdy_n_m | dst_n;
        reset = rst; channel_up = cu; tx_dst_rdy_n = dst_n;
        rx_d = rx;   rx_src_rdy_n = rx_n;
        if (rst) begin
            gs_m = SEED; txrdy_n_m = 1'b1; mode_m = M_HUNT;
            run_m = 0; miss_m = 0; cnt_m = 0; pulse_m = 1'b0; es_m = 16'h0000;
        end else begin
            if (!txrdy_n_m && !dst_n) gs_m = nxt(gs_m);
            txrdy_n_m = !cu;
            pulse_m = 1'b0;
            ok = (rx == stream(es_m));
            if (!cu) begin
                mode_m = M_HUNT;
            end else if (!rx_n) begin
                case (mode_m)
                    M_HUNT: begin
                        if (rx[0:15] != 16'h0000) begin
                            es_m = nxt(rx[0:15]); run_m = 0; mode_m = M_VERIFY;
                        end
                    end
                    M_VERIFY: begin
                        if (ok) begin
                            es_m = nxt(es_m); run_m++;
                            if (run_m == LOCK_WORDS) begin mode_m = M_LOCK; miss_m = 0; end
                        end else begin
                            mode_m = M_HUNT;
                        end
                    end
                    default: begin
                        es_m = nxt(es_m);
                        if (ok) begin
                            miss_m = 0;
                        end else begin
                            pulse_m = 1'b1;
                            if (cnt_m < (2**ERR_W) - 1) cnt_m++;
                            miss_m++;
                            if (miss_m == LOSS_WORDS) mode_m = M_HUNT;
                        end
                    end
                endcase
            end
        end
        @(posedge clk);
        #1;
        check_val("tx_d",         64'(tx_d),       64'(stream(gs_m)));
        check_val("tx_src_rdy_n", 64'(tx_src_rdy_n), 64'(txrdy_n_m));
        check_val("locked",       64'(locked),     64'(mode_m == M_LOCK));
        check_val("err_pulse",    64'(err_pulse),  64'(pulse_m));
        check_val("err_count",    64'(err_count),  64'(cnt_m));
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, nf, 1'b0);
        step(1'b1, 1'b0, 1'b0, nf, 1'b0);
    endtask

    task automatic run_clean(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b1, 1'b0, nf, 1'b0);
    endtask

    task automatic relock();
        do_reset();
        run_clean(2 + LOCK_WORDS);
        check_val("relock", 64'(locked), 64'd1);
    endtask

    function automatic logic [0:DW-1] rand_flip();
        logic [0:DW-1] f;
        f = {DW{1'b0}};
        f[$urandom_range(0, DW-1)] = 1'b1;
        return f;
    endfunction

    initial begin
        logic [0:DW-1] f;
        logic          cu_v, dst_v, zw_v, rst_v;
        int            pulses;

        // Reset values
        do_reset();
        check_val("rst_tx_d",   64'(tx_d), 64'(stream(SEED)));
        check_val("rst_rdy_n",  64'(tx_src_rdy_n), 64'd1);
        check_val("rst_locked", 64'(locked), 64'd0);
        check_val("rst_count",  64'(err_count), 64'd0);

        // Loopback lock latency: seed word plus LOCK_WORDS matches
        step(1'b0, 1'b1, 1'b0, nf, 1'b0);
        check_val("rdy_follows_cu", 64'(tx_src_rdy_n), 64'd0);
        run_clean(LOCK_WORDS);
        check_val("lock_early", 64'(locked), 64'd0);
        run_clean(1);
        check_val("lock_on_time", 64'(locked), 64'd1);

        // Backpressure with random 50% ready
        for (int k = 0; k < 400; k++) begin
            dst_v = 1'($urandom_range(0, 1));
            step(1'b0, 1'b1, dst_v, nf, 1'b0);
        end
        check_val("bp_count", 64'(err_count), 64'd0);

        // Single-bit error: bit 5 of lane 1
        relock();
        f = nf; f[16 + 15 - 5] = 1'b1;
        pulses = 0;
        step(1'b0, 1'b1, 1'b0, f, 1'b0);
        pulses += int'(err_pulse);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 1'b0, nf, 1'b0);
            pulses += int'(err_pulse);
        end
        check_val("single_pulses", 64'(pulses), 64'd1);
        check_val("single_count",  64'(err_count), 64'd1);
        check_val("single_locked", 64'(locked), 64'd1);

        // Burst of LOSS_WORDS corrupted words drops lock, then re-lock
        relock();
        for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 1'b0, rand_flip(), 1'b0);
        check_val("burst_count",  64'(err_count), 64'd8);
        check_val("burst_unlock", 64'(locked), 64'd0);
        run_clean(1 + LOCK_WORDS);
        check_val("burst_relock", 64'(locked), 64'd1);

        // Channel drop for 3 cycles
        relock();
        step(1'b0, 1'b0, 1'b0, nf, 1'b0);
        check_val("drop_rdy_n",   64'(tx_src_rdy_n), 64'd1);
        check_val("drop_locked",  64'(locked), 64'd0);
        step(1'b0, 1'b0, 1'b0, nf, 1'b0);
        step(1'b0, 1'b0, 1'b0, nf, 1'b0);
        check_val("drop_count",   64'(err_count), 64'd0);
        run_clean(2 + LOCK_WORDS);
        check_val("drop_relock",  64'(locked), 64'd1);

        // Zero lane 0 words are ignored while hunting
        do_reset();
        step(1'b0, 1'b1, 1'b0, nf, 1'b0);
        for (int k = 0; k < 6; k++) step(1'b0, 1'b1, 1'b0, nf, 1'b1);
        check_val("zero_ignored", 64'(locked), 64'd0);
        run_clean(1 + LOCK_WORDS);
        check_val("zero_then_lock", 64'(locked), 64'd1);

        // Saturation: 20 isolated errors on a 4-bit counter
        relock();
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b1, 1'b0, rand_flip(), 1'b0);
            step(1'b0, 1'b1, 1'b0, nf, 1'b0);
        end
        check_val("sat_count",  64'(err_count), 64'd15);
        check_val("sat_locked", 64'(locked), 64'd1);

        // Long clean loopback with random backpressure
        relock();
        for (int k = 0; k < 10000; k++) begin
            dst_v = 1'($urandom_range(0, 1));
            step(1'b0, 1'b1, dst_v, nf, 1'b0);
        end
        check_val("soak_count",  64'(err_count), 64'd0);
        check_val("soak_locked", 64'(locked), 64'd1);

        // Random mix of drops, stalls, errors, zero words and resets
        for (int k = 0; k < 3000; k++) begin
            cu_v  = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
            dst_v = 1'($urandom_range(0, 1));
            zw_v  = ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0;
            rst_v = ($urandom_range(0, 999) < 2) ? 1'b1 : 1'b0;
            f     = ($urandom_range(0, 99) < 5) ? rand_flip() : nf;
            step(rst_v, cu_v, dst_v, f, zw_v);
        end

        // Reset in the middle of LOCK with a nonzero error count
        relock();
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 1'b0, rand_flip(), 1'b0);
            step(1'b0, 1'b1, 1'b0, nf, 1'b0);
        end
        check_val("pre_rst_count", 64'(err_count), 64'd3);
        step(1'b1, 1'b1, 1'b0, nf, 1'b0);
        check_val("mid_rst_tx_d",   64'(tx_d), 64'(stream(SEED)));
        check_val("mid_rst_rdy_n",  64'(tx_src_rdy_n), 64'd1);
        check_val("mid_rst_locked", 64'(locked), 64'd0);
        check_val("mid_rst_pulse",  64'(err_pulse), 64'd0);
        check_val("mid_rst_count",  64'(err_count), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
